// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the pipeline stall/flush/halt controller.
//   state_t      : controller FSM states (RUN, DRAIN, HALTED)
//   REG_ZERO     : architectural zero register index; never a real hazard
//   reg_hazard() : true when a load destination actually feeds a source
// ---------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A write to the zero register is discarded, so it can never create a hazard.
  function automatic logic reg_hazard(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use detector.
//   i_ex_mem_read : instruction in EX is a load
//   i_ex_rt       : destination register of that load
//   i_id_rs       : rs source of the instruction in ID
//   i_id_rt       : rt field of the instruction in ID
//   i_id_uses_rt  : ID instruction actually reads rt
//   o_load_use    : ID needs the load result before it is available
// ---------------------------------------------------------------------------
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  output logic       o_load_use
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit   = reg_hazard(i_ex_rt, i_id_rs);
  // rt only matters when the ID instruction really sources it (e.g. not an I-type dest).
  assign w_rt_hit   = i_id_uses_rt & reg_hazard(i_ex_rt, i_id_rt);
  assign o_load_use = i_ex_mem_read & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Stall / flush / halt controller for a 5-stage pipeline.
// Parameters:
//   DRAIN_CYCLES : cycles after halt detection until EX/MEM/WB are empty
//   CNT_W        : width of the saturating stall-cycle counter
// Ports:
//   clk                  : clock, all state on rising edge
//   rst_b                : synchronous reset, ACTIVE-HIGH despite the name
//   id_rs/id_rt          : source fields of the instruction in ID
//   id_uses_rt           : ID instruction reads rt
//   ex_mem_read/ex_rt    : load in EX and its destination
//   branch_taken_ex      : taken branch/jump resolved in EX
//   halted_controller_id : halt decoded in ID
//   mem_busy             : data memory not ready, freeze everything
//   pc_en/ifid_en        : PC and IF/ID write enables
//   ifid_flush           : IF/ID loads a NOP
//   idex_bubble          : ID/EX loads a NOP
//   halted               : processor fully stopped
//   stall_cycles         : RUN cycles lost to mem_busy or load-use
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken_ex,
  input  logic             halted_controller_id,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned   DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next_state;
  logic [DW-1:0]    r_drain_cnt;
  logic [DW-1:0]    w_drain_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall_inc;
  logic             w_load_use;

  hazard_detect u_hazard_detect (
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rt       (ex_rt),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_id_uses_rt  (id_uses_rt),
    .o_load_use    (w_load_use)
  );

  assign stall_cycles = r_stall_cnt;

  // Next-state, drain counter and pipeline-enable decode.
  always_comb begin
    w_next_state = r_state;
    w_drain_next = r_drain_cnt;
    w_stall_inc  = 1'b0;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b1;
    halted       = 1'b0;

    if (rst_b) begin
      // Reset overrides the state: flush both buffers so nothing leaks out.
      w_next_state = ST_RUN;
      w_drain_next = '0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (mem_busy) begin
            // Full freeze: every buffer simply holds.
            idex_bubble = 1'b0;
            w_stall_inc = 1'b1;
          end else if (branch_taken_ex) begin
            // Squash the wrong path, including any halt sitting in ID.
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (w_load_use) begin
            // Hold IF/ID one cycle; halt in ID (if any) is re-seen next cycle.
            idex_bubble = 1'b1;
            w_stall_inc = 1'b1;
          end else if (halted_controller_id) begin
            // Halt moves on into EX; IF/ID gets a NOP so it is not seen twice.
            ifid_en      = 1'b1;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b0;
            w_next_state = ST_DRAIN;
            w_drain_next = DRAIN_LOAD;
          end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_bubble = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!mem_busy) begin
            if (r_drain_cnt == '0) begin
              w_next_state = ST_HALTED;
            end else begin
              w_drain_next = r_drain_cnt - DW'(1);
            end
          end else begin
            w_drain_next = r_drain_cnt;
          end
        end
        ST_HALTED: begin
          halted = 1'b1;
        end
        default: begin
          // Corrupted encoding: keep pipeline frozen and recover to RUN.
          w_next_state = ST_RUN;
          w_drain_next = '0;
        end
      endcase
    end
  end

  // State, drain counter and saturating stall counter registers.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_drain_next;
      if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int unsigned DRAIN_CYCLES = 3;
  localparam int unsigned CNT_W        = 16;
  localparam int          STALL_MAX    = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_b;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             branch_taken_ex;
  logic             halted_controller_id;
  logic             mem_busy;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = running, 1 = draining, 2 = stopped.
  int m_mode  = 0;
  int m_drain = 0;
  int m_stall = 0;

  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .rst_b                (rst_b),
    .id_rs                (id_rs),
    .id_rt                (id_rt),
    .id_uses_rt           (id_uses_rt),
    .ex_mem_read          (ex_mem_read),
    .ex_rt                (ex_rt),
    .branch_taken_ex      (branch_taken_ex),
    .halted_controller_id (halted_controller_id),
    .mem_busy             (mem_busy),
    .pc_en                (pc_en),
    .ifid_en              (ifid_en),
    .ifid_flush           (ifid_flush),
    .idex_bubble          (idex_bubble),
    .halted               (halted),
    .stall_cycles         (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_load_use();
    if (!ex_mem_read || ex_rt == 5'd0) return 1'b0;
    if (ex_rt == id_rs) return 1'b1;
    return id_uses_rt && (ex_rt == id_rt);
  endfunction

  task automatic check_outputs();
    bit e_pc, e_ie, e_fl, e_bu, e_h;
    bit lu;
    lu = model_load_use();
    e_pc = 0; e_ie = 0; e_fl = 0; e_bu = 1; e_h = 0;
    if (rst_b) begin
      e_fl = 1;
    end else if (m_mode == 0) begin
      if (mem_busy)                  begin e_bu = 0; end
      else if (branch_taken_ex)      begin e_pc = 1; e_ie = 1; e_fl = 1; end
      else if (lu)                   begin e_bu = 1; end
      else if (halted_controller_id) begin e_ie = 1; e_fl = 1; e_bu = 0; end
      else                           begin e_pc = 1; e_ie = 1; e_bu = 0; end
    end else if (m_mode == 2) begin
      e_h = 1;
    end
    chk("pc_en", pc_en, e_pc);
    chk("ifid_en", ifid_en, e_ie);
    chk("ifid_flush", ifid_flush, e_fl);
    chk("idex_bubble", idex_bubble, e_bu);
    chk("halted", halted, e_h);
    chk("stall_cycles", stall_cycles, m_stall[CNT_W-1:0]);
  endtask

  task automatic model_update();
    bit lu;
    lu = model_load_use();
    if (rst_b) begin
      m_mode = 0; m_drain = 0; m_stall = 0;
    end else if (m_mode == 0) begin
      if ((mem_busy || (!branch_taken_ex && lu)) && m_stall < STALL_MAX) m_stall++;
      if (!mem_busy && !branch_taken_ex && !lu && halted_controller_id) begin
        m_mode  = 1;
        m_drain = DRAIN_CYCLES - 1;
      end
    end else if (m_mode == 1) begin
      if (!mem_busy) begin
        if (m_drain == 0) m_mode = 2;
        else m_drain--;
      end
    end
  endtask

  // One clock: drive at negedge, check mid-cycle, let the edge happen, advance model.
  task automatic cycle(input logic a_rst, input logic a_mb, input logic a_br, input logic a_hl,
                       input logic a_mr, input logic a_ut, input logic [4:0] a_rs,
                       input logic [4:0] a_rt, input logic [4:0] a_ert);
    @(negedge clk);
    rst_b = a_rst; mem_busy = a_mb; branch_taken_ex = a_br; halted_controller_id = a_hl;
    ex_mem_read = a_mr; id_uses_rt = a_ut; id_rs = a_rs; id_rt = a_rt; ex_rt = a_ert;
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
  endtask

  initial begin
    rst_b = 1'b1; mem_busy = 1'b0; branch_taken_ex = 1'b0; halted_controller_id = 1'b0;
    ex_mem_read = 1'b0; id_uses_rt = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    repeat (2) @(posedge clk);

    // Reset state, then plain running.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle();

    // Load-use on rs: one-cycle stall, counter goes to 1.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 5'd0, 5'd8);
    #1 chk("lu_stall_count", stall_cycles, 32'd1);
    idle();

    // Load to r0 never stalls.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    // rt match only counts when rt is a source.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 5'd9, 5'd9);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 5'd9, 5'd9);
    // mem_busy freeze beats branch.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);

    // Wrong-path halt squashed by a taken branch.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    idle();

    // Load-use beats halt; halt detected on the following cycle.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd5);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 5'd5);
    // Drain: busy on the second drain cycle, branch ignored while draining.
    idle();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    idle();
    #1 chk("halt_not_yet", halted, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    #1 chk("halt_latency5", halted, 32'd1);
    // Halted is absorbing.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 5'd2, 5'd7);
    idle();

    // Reset in the middle of a drain.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    idle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    #1 chk("mid_drain_rst_stall", stall_cycles, 32'd0);
    idle();

    // Saturation of the stall counter.
    for (int i = 0; i < 70000; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    end
    #1 chk("stall_saturate", stall_cycles, 32'd65535);
    idle();

    // Randomized traffic against the model.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(49) == 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
            ($urandom_range(11) == 0), $urandom_range(1), $urandom_range(1),
            5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
